// File: rtl/boot_memory_arbiter_if.sv
// Bus bundle between the boot memory arbiter, its two requesters (CPU, loader) and the
// single-port boot memory. The arbiter takes the slave view; requesters and memory take the master view.
interface boot_memory_arbiter_if #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 8
);
   logic                    CPU_REQ;
   logic                    CPU_WR;
   logic [ADDRESS_BITS-1:0] CPU_ADDRESS;
   logic [BITS-1:0]         CPU_DATA_IN;
   logic                    CPU_GNT;
   logic [BITS-1:0]         CPU_DATA_OUT;
   logic                    CPU_VALID;
   logic                    CPU_HOLD;

   logic                    LDR_REQ;
   logic                    LDR_WR;
   logic [ADDRESS_BITS-1:0] LDR_ADDRESS;
   logic [BITS-1:0]         LDR_DATA_IN;
   logic                    LDR_LOCK;
   logic                    LDR_DONE;
   logic                    LDR_GNT;
   logic [BITS-1:0]         LDR_DATA_OUT;
   logic                    LDR_VALID;

   logic [ADDRESS_BITS-1:0] MEM_ADDRESS;
   logic [BITS-1:0]         MEM_DATA_IN;
   logic                    MEM_WR;
   logic [BITS-1:0]         MEM_DATA_OUT;

   modport slave (
      input  CPU_REQ, CPU_WR, CPU_ADDRESS, CPU_DATA_IN,
      output CPU_GNT, CPU_DATA_OUT, CPU_VALID, CPU_HOLD,
      input  LDR_REQ, LDR_WR, LDR_ADDRESS, LDR_DATA_IN, LDR_LOCK, LDR_DONE,
      output LDR_GNT, LDR_DATA_OUT, LDR_VALID,
      output MEM_ADDRESS, MEM_DATA_IN, MEM_WR,
      input  MEM_DATA_OUT
   );

   modport master (
      output CPU_REQ, CPU_WR, CPU_ADDRESS, CPU_DATA_IN,
      input  CPU_GNT, CPU_DATA_OUT, CPU_VALID, CPU_HOLD,
      output LDR_REQ, LDR_WR, LDR_ADDRESS, LDR_DATA_IN, LDR_LOCK, LDR_DONE,
      input  LDR_GNT, LDR_DATA_OUT, LDR_VALID,
      input  MEM_ADDRESS, MEM_DATA_IN, MEM_WR,
      output MEM_DATA_OUT
   );
endinterface

// File: rtl/boot_memory_arbiter.sv
// Arbitrates the single-port boot memory between the CPU and the boot loader: loader-only fill
// phase after reset, then CPU priority with a loader starvation guard and a loader lock mode.
module boot_memory_arbiter #(
   parameter int BITS          = 16,
   parameter int ADDRESS_BITS  = 8,
   parameter int WAIT_BITS     = 4,
   parameter int MAX_WAIT      = 8,
   parameter int LOAD_ON_RESET = 1
) (
   input logic                   CLK,
   input logic                   RST,
   boot_memory_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_LOCKED} state_t;

   localparam logic [WAIT_BITS-1:0] MAX_W = WAIT_BITS'(MAX_WAIT);

   state_t                  state;
   logic [WAIT_BITS-1:0]    wait_cnt;
   logic                    hold_q;
   logic                    cpu_vld_p1;
   logic                    ldr_vld_p1;

   logic                    cpu_gnt_c;
   logic                    ldr_gnt_c;
   logic [ADDRESS_BITS-1:0] mem_addr_c;
   logic [BITS-1:0]         mem_din_c;
   logic                    mem_wr_c;

   function automatic logic [WAIT_BITS-1:0] sat_inc(input logic [WAIT_BITS-1:0] v);
      return (v == MAX_W) ? v : v + 1'b1;
   endfunction

   // Stage p0: grant decision and memory mux, all combinational in the request cycle
   always_comb begin
      cpu_gnt_c = 1'b0;
      ldr_gnt_c = 1'b0;
      case (state)
         S_LOAD, S_LOCKED: ldr_gnt_c = bus.LDR_REQ;
         S_RUN: begin
            ldr_gnt_c = bus.LDR_REQ && ((wait_cnt == MAX_W) || !bus.CPU_REQ);
            cpu_gnt_c = bus.CPU_REQ && !ldr_gnt_c;
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_addr_c = bus.CPU_ADDRESS;
      mem_din_c  = bus.CPU_DATA_IN;
      mem_wr_c   = 1'b0;
      if (ldr_gnt_c) begin
         mem_addr_c = bus.LDR_ADDRESS;
         mem_din_c  = bus.LDR_DATA_IN;
         mem_wr_c   = bus.LDR_WR;
      end else if (cpu_gnt_c) begin
         mem_wr_c   = bus.CPU_WR;
      end
   end

   assign bus.CPU_GNT     = cpu_gnt_c;
   assign bus.LDR_GNT     = ldr_gnt_c;
   assign bus.MEM_ADDRESS = mem_addr_c;
   assign bus.MEM_DATA_IN = mem_din_c;
   assign bus.MEM_WR      = mem_wr_c;

   // Stage p1: state, starvation counter and read-valid flags track the memory's registered read
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= (LOAD_ON_RESET != 0) ? S_LOAD : S_RUN;
         hold_q     <= (LOAD_ON_RESET != 0);
         wait_cnt   <= '0;
         cpu_vld_p1 <= 1'b0;
         ldr_vld_p1 <= 1'b0;
      end else begin
         cpu_vld_p1 <= cpu_gnt_c && !bus.CPU_WR;
         ldr_vld_p1 <= ldr_gnt_c && !bus.LDR_WR;
         case (state)
            S_LOAD: begin
               wait_cnt <= '0;
               if (bus.LDR_DONE) begin
                  state  <= S_RUN;
                  hold_q <= 1'b0;
               end
            end
            S_RUN: begin
               hold_q <= 1'b0;
               if (!bus.LDR_REQ || ldr_gnt_c) wait_cnt <= '0;
               else                           wait_cnt <= sat_inc(wait_cnt);
               if (ldr_gnt_c && bus.LDR_LOCK) state <= S_LOCKED;
            end
            S_LOCKED: begin
               hold_q   <= 1'b0;
               wait_cnt <= '0;
               if (!bus.LDR_LOCK) state <= S_RUN;
            end
            default: begin
               state    <= S_RUN;
               hold_q   <= 1'b0;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.CPU_HOLD     = hold_q;
   assign bus.CPU_VALID    = cpu_vld_p1;
   assign bus.LDR_VALID    = ldr_vld_p1;
   assign bus.CPU_DATA_OUT = bus.MEM_DATA_OUT;
   assign bus.LDR_DATA_OUT = bus.MEM_DATA_OUT;

endmodule

// File: tb/tb_boot_memory_arbiter.sv
// Directed bench for boot_memory_arbiter: vector table for load/run/lock flows plus hand-written
// sequences for starvation ratio and reset during an in-flight read. Includes a 1-cycle memory model.
module tb_boot_memory_arbiter;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic mem_clr = 1'b1;
   always #5 CLK = ~CLK;

   boot_memory_arbiter_if #(.BITS(16), .ADDRESS_BITS(8)) bus ();

   boot_memory_arbiter #(
      .BITS(16), .ADDRESS_BITS(8), .WAIT_BITS(4), .MAX_WAIT(8), .LOAD_ON_RESET(1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   // Single-port memory with one-cycle registered read, write on the grant edge
   logic [15:0] mem [256];
   logic [15:0] mem_q;
   always @(posedge CLK) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem_q <= '0;
      end else begin
         if (bus.MEM_WR) mem[bus.MEM_ADDRESS] <= bus.MEM_DATA_IN;
         mem_q <= mem[bus.MEM_ADDRESS];
      end
   end
   assign bus.MEM_DATA_OUT = mem_q;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        cpu_req, cpu_wr;
      logic [7:0]  cpu_addr;
      logic [15:0] cpu_din;
      logic        ldr_req, ldr_wr;
      logic [7:0]  ldr_addr;
      logic [15:0] ldr_din;
      logic        ldr_lock, ldr_done;
      logic        e_cpu_gnt, e_ldr_gnt, e_mem_wr, e_hold, e_cpu_vld, e_ldr_vld;
      logic [15:0] e_data;
   } vec_t;

   task automatic drive(input vec_t v);
      bus.CPU_REQ     = v.cpu_req;
      bus.CPU_WR      = v.cpu_wr;
      bus.CPU_ADDRESS = v.cpu_addr;
      bus.CPU_DATA_IN = v.cpu_din;
      bus.LDR_REQ     = v.ldr_req;
      bus.LDR_WR      = v.ldr_wr;
      bus.LDR_ADDRESS = v.ldr_addr;
      bus.LDR_DATA_IN = v.ldr_din;
      bus.LDR_LOCK    = v.ldr_lock;
      bus.LDR_DONE    = v.ldr_done;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(posedge CLK); #1;
      drive(v);
      @(negedge CLK);
      check($sformatf("v%0d_cpu_gnt", idx),   bus.CPU_GNT,   v.e_cpu_gnt);
      check($sformatf("v%0d_ldr_gnt", idx),   bus.LDR_GNT,   v.e_ldr_gnt);
      check($sformatf("v%0d_mem_wr", idx),    bus.MEM_WR,    v.e_mem_wr);
      check($sformatf("v%0d_mem_addr", idx),  bus.MEM_ADDRESS, v.e_ldr_gnt ? v.ldr_addr : v.cpu_addr);
      check($sformatf("v%0d_cpu_hold", idx),  bus.CPU_HOLD,  v.e_hold);
      check($sformatf("v%0d_cpu_valid", idx), bus.CPU_VALID, v.e_cpu_vld);
      check($sformatf("v%0d_ldr_valid", idx), bus.LDR_VALID, v.e_ldr_vld);
      if (v.e_cpu_vld) check($sformatf("v%0d_cpu_data", idx), bus.CPU_DATA_OUT, v.e_data);
      if (v.e_ldr_vld) check($sformatf("v%0d_ldr_data", idx), bus.LDR_DATA_OUT, v.e_data);
   endtask

   vec_t vecs [17];
   vec_t idle;

   initial begin
      //           creq cwr caddr  cdin      lreq lwr laddr  ldin      lck dn  cg lg mw hd cv lv data
      vecs[0]  = '{1, 0, 8'h00, 16'h0000, 1, 1, 8'h00, 16'h1004, 0, 0, 0, 1, 1, 1, 0, 0, 16'h0000};
      vecs[1]  = '{1, 0, 8'h00, 16'h0000, 1, 1, 8'h01, 16'h4e00, 0, 0, 0, 1, 1, 1, 0, 0, 16'h0000};
      vecs[2]  = '{1, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h1006, 1, 0, 0, 1, 1, 1, 0, 0, 16'h0000};
      vecs[3]  = '{1, 0, 8'h00, 16'h0000, 1, 1, 8'h21, 16'h3011, 0, 1, 0, 1, 1, 1, 0, 0, 16'h0000};
      vecs[4]  = '{1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000};
      vecs[5]  = '{1, 0, 8'h01, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 0, 1, 0, 16'h1004};
      vecs[6]  = '{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 0, 0, 1, 0, 16'h4e00};
      vecs[7]  = '{1, 1, 8'h10, 16'hBEEF, 1, 0, 8'h10, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000};
      vecs[8]  = '{0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
      vecs[9]  = '{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF};
      vecs[10] = '{0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
      vecs[11] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h21, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h1006};
      vecs[12] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h22, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h3011};
      vecs[13] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h23, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h0000};
      vecs[14] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h24, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000};
      vecs[15] = '{1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0000};
      vecs[16] = '{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 16'h1004};
      idle     = '{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000};

      drive(idle);
      bus.CPU_REQ = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      mem_clr = 1'b0;

      // Reset state: loader-fill phase, CPU held and never granted
      @(negedge CLK);
      check("rst_cpu_hold",  bus.CPU_HOLD,  1'b1);
      check("rst_cpu_gnt",   bus.CPU_GNT,   1'b0);
      check("rst_cpu_valid", bus.CPU_VALID, 1'b0);
      check("rst_ldr_valid", bus.LDR_VALID, 1'b0);
      check("rst_wait_cnt",  dut.wait_cnt,  0);

      for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

      // Starvation guard: with both requesting, 8 CPU grants then one loader grant, repeating
      @(posedge CLK); #1;
      drive(idle);
      bus.CPU_REQ = 1'b1; bus.CPU_ADDRESS = 8'h00;
      bus.LDR_REQ = 1'b1; bus.LDR_ADDRESS = 8'h01;
      for (int k = 0; k < 27; k++) begin
         @(negedge CLK);
         check($sformatf("starve%0d_cpu_gnt", k), bus.CPU_GNT, (k % 9) != 8);
         check($sformatf("starve%0d_ldr_gnt", k), bus.LDR_GNT, (k % 9) == 8);
      end

      // Reset arriving right after a CPU read grant drops the pending result
      @(posedge CLK); #1;
      bus.CPU_ADDRESS = 8'h01;
      @(negedge CLK);
      check("rstrd_cpu_gnt", bus.CPU_GNT, 1'b1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check("rstrd_wait_pre", dut.wait_cnt, 1);
      check("rstrd_valid_pre", bus.CPU_VALID, 1'b1);
      check("rstrd_data_pre", bus.CPU_DATA_OUT, 16'h4e00);
      @(posedge CLK); #1;
      RST = 1'b0;
      bus.LDR_REQ = 1'b0;
      @(negedge CLK);
      check("rstrd_cpu_valid", bus.CPU_VALID, 1'b0);
      check("rstrd_cpu_hold",  bus.CPU_HOLD,  1'b1);
      check("rstrd_cpu_gnt",   bus.CPU_GNT,   1'b0);
      check("rstrd_wait_cnt",  dut.wait_cnt,  0);
      @(negedge CLK);
      check("rstrd_cpu_valid2", bus.CPU_VALID, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
